// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//
// Bundles every signal between the memory port arbiter and the outside world:
// the instruction-fetch requester (if_*), the load/store requester (ls_*),
// the shared memory bus (mem_*) and the arbiter status (busy, owner).
//
// Modports:
//   master - the arbiter's view; it owns the memory bus and answers the requesters
//   slave  - the environment's view (requesters plus memory)
//
// Signals:
//   if_req, if_addr            fetch request and address
//   if_rdata, if_done, if_err  fetch result word, completion pulse, timeout pulse
//   ls_req, ls_we, ls_be,
//   ls_addr, ls_wdata          load/store request, direction, byte enables, address, data
//   ls_rdata, ls_done, ls_err  load result word, completion pulse, timeout pulse
//   mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata        registered bus transaction
//   mem_ack, mem_rdata         memory completion and read data (same cycle)
//   busy                       transaction in flight or being reported
//   owner                      0 = IF, 1 = LS; owner of the current or last grant
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_err;

    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        ls_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        owner;

    modport master (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  mem_ack, mem_rdata,
        output if_rdata, if_done, if_err,
        output ls_rdata, ls_done, ls_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output busy, owner
    );

    modport slave (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output mem_ack, mem_rdata,
        input  if_rdata, if_done, if_err,
        input  ls_rdata, ls_done, ls_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the CPU's single memory port between instruction fetch (IF, read
// only) and the load/store path (LS, read/write with byte enables). One
// transaction is latched at grant time and held on the bus until the memory
// acknowledges it or it times out; the result goes back to the owning
// requester as a one-cycle done or err pulse.
//
// Parameters:
//   RR_MODE        0 = LS has fixed priority, 1 = round-robin on ties
//   TIMEOUT_CYCLES bus cycles without mem_ack before aborting (0 = never)
//   CNT_W          timeout counter width, TIMEOUT_CYCLES < 2**CNT_W
//
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset; aborts any in-flight transaction
//   bus  mem_port_arbiter_if.master, requester, memory and status signals
module mem_port_arbiter #(
    parameter bit          RR_MODE        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_done_q, if_done_d;
    logic        if_err_q, if_err_d;
    logic        ls_done_q, ls_done_d;
    logic        ls_err_q, ls_err_d;
    logic        busy_q, busy_d;
    logic        grant_ls;

    // Next-state and next-output logic. owner_q doubles as the round-robin
    // pointer: it names the previous grant, and resets to IF so that LS wins
    // the first tie.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        ls_done_d   = 1'b0;
        ls_err_d    = 1'b0;
        busy_d      = busy_q;
        grant_ls    = 1'b0;

        case (state_q)
            IDLE: begin
                // LS takes a tie unless round-robin says LS had the last grant.
                grant_ls = bus.ls_req &&
                           (!bus.if_req || (RR_MODE == 1'b0) || (owner_q == OWN_IF));
                if (bus.if_req || bus.ls_req) begin
                    owner_d   = grant_ls ? OWN_LS : OWN_IF;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = BUSY;
                    if (grant_ls) begin
                        mem_we_d    = bus.ls_we;
                        mem_be_d    = bus.ls_be;
                        mem_addr_d  = bus.ls_addr;
                        mem_wdata_d = bus.ls_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = 4'hF;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = 32'h0;
                    end
                end
            end

            BUSY: begin
                // An ack in the same cycle as the timeout limit still completes.
                if (bus.mem_ack) begin
                    if (!mem_we_q) begin
                        if (owner_q == OWN_LS) begin
                            ls_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                    if (owner_q == OWN_LS) begin
                        ls_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    if (owner_q == OWN_LS) begin
                        ls_err_d = 1'b1;
                    end else begin
                        if_err_d = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered here; reset drops everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            ls_done_q   <= 1'b0;
            ls_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            ls_done_q   <= ls_done_d;
            ls_err_q    <= ls_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_err    = if_err_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: instruction fetch (IF, read-only) and the load/store path (LS, read/write with byte enables), which serves the L_TYPE and S_TYPE opcodes.
- Sits between the fetch/decode/LSU sequencers and the memory bus. It latches one transaction and drives it on the bus until the memory acknowledges or the transaction times out.
- Returns the result to the owning requester as a one-cycle done or err pulse.

Parameters:
- RR_MODE, 0, 0 = LS has fixed priority over IF; 1 = round-robin between IF and LS when both request.
- TIMEOUT_CYCLES, 255, number of bus cycles without mem_ack before a transaction is aborted with an error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be less than 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request; held until if_done or if_err
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word; updated only on an IF read ack
- if_done  out  1  one-cycle pulse: IF transaction complete
- if_err  out  1  one-cycle pulse: IF transaction timed out
- ls_req  in  1  load/store request; held until ls_done or ls_err
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  byte enables
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data
- ls_rdata  out  32  load data; updated only on an LS read ack
- ls_done  out  1  one-cycle pulse: LS transaction complete
- ls_err  out  1  one-cycle pulse: LS transaction timed out
- mem_req  out  1  bus request; held high until mem_ack or timeout
- mem_we  out  1  bus write enable
- mem_be  out  4  bus byte enables
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle
- mem_rdata  in  32  memory read data
- busy  out  1  high in BUSY and RESP
- owner  out  1  0 = IF, 1 = LS; owner of the current or most recent grant

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - state = IDLE; all outputs = 0; timeout counter = 0.
  - Round-robin pointer = 0, so LS wins the first tie.
  - Reset in any state aborts the in-flight transaction: mem_req drops on the next cycle and no done/err pulse is issued.
- States: IDLE, BUSY, RESP.
- IDLE, sampled each edge:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesters, RR_MODE=0: grant LS.
  - Both requesters, RR_MODE=1: grant the requester that did not own the previous grant.
  - On grant: set owner; latch addr, we, be and wdata into the mem_* registers (IF: we=0, be=4'hF, wdata=0); set mem_req=1; clear the counter; go to BUSY.
- BUSY:
  - Request fields are not re-sampled; the mem_* outputs stay constant while mem_req=1.
  - mem_ack=1 and the transaction is a read: capture mem_rdata into the owner's rdata register.
  - mem_ack=1, read or write: drop mem_req; raise the owner's done; go to RESP.
  - mem_ack=0: counter increments.
  - Counter = TIMEOUT_CYCLES-1 while mem_ack=0 (TIMEOUT_CYCLES≠0): drop mem_req; raise the owner's err; leave rdata unchanged; go to RESP.
  - mem_ack wins over timeout when both occur in the same cycle.
- RESP:
  - done/err is high for exactly this one cycle; requests are ignored.
  - Next state is IDLE.
  - The requester must deassert req, or present a new transaction, by the cycle after the pulse.
- Latency:
  - Request seen at edge k → mem_req high after edge k.
  - mem_ack in cycle k+m → done high in cycle k+m+1.
  - Next grant at edge k+m+3 at the earliest.
  - Back-to-back throughput: one transaction per (ack latency + 3) cycles.
- mem_ack while in IDLE or RESP is ignored.
- A requester whose req is high while the other owns the bus waits without loss of its request.
- Stores leave ls_rdata unchanged. If the store completes normally, ls_done pulses.
- owner is held after completion until the next grant.

Test Plan:
- Single IF fetch, if_addr=0x100, memory acks 2 cycles after mem_req with 0x00500093 → mem_addr=0x100, mem_we=0, mem_be=F; if_rdata=0x00500093; if_done high exactly 1 cycle; ls_done stays 0.
- LS store, ls_addr=0x2004, ls_be=4'b0011, ls_wdata=0xDEADBEEF, immediate ack → mem_we=1, mem_be=3, mem_wdata=0xDEADBEEF; ls_done pulse; ls_rdata unchanged (0).
- if_req and ls_req rise together, RR_MODE=0, four back-to-back rounds → LS granted every round; IF granted only once ls_req drops. With RR_MODE=1 the grants alternate LS, IF, LS, IF.
- TIMEOUT_CYCLES=4, IF request, memory never acks → mem_req high exactly 4 cycles, then if_err 1-cycle pulse; if_done=0; if_rdata keeps its old value; return to IDLE.
- mem_ack arrives in the same cycle the counter hits its limit → done (not err) and data captured.
- rst asserted for one cycle mid-BUSY → next cycle all outputs 0 with no done/err pulse. A stray mem_ack after the reset is ignored, and a new request is granted normally.
